pc_sequencer: RTL and testbench

- Control block that drives the ProgramCounter's `branch_en`, `increment_en` and `branch_offset` each cycle in the single-cycle RISC-V core.
- Arbitrates between sequential fetch, taken branch, jump, stall and halt requests.
- Provides a post-reset boot delay, a halt/resume/single-step debug path, and a count of PC advances.

---
 rtl/pc_seq_pkg.sv | 22 ++
 rtl/pc_seq_arb.sv | 60 ++++++
 rtl/pc_sequencer.sv | 135 +++++++++++++
 tb/tb_pc_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
// State encoding is fixed (BOOT=0 .. STEP=4) so debug tools can decode it.
// align_mask() clears the byte-offset bits below one instruction word.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      ST_BOOT = 3'd0,
      ST_IDLE = 3'd1,
      ST_RUN  = 3'd2,
      ST_HALT = 3'd3,
      ST_STEP = 3'd4
   } pc_seq_state_t;

   localparam int PC_STEP_BYTES = 4;
   localparam int OFFSET_W      = 32;

   // Mask that keeps only word-aligned offset bits.
   function automatic logic [OFFSET_W-1:0] align_mask();
      return ~(OFFSET_W'(PC_STEP_BYTES - 1));
   endfunction

endpackage

// File: rtl/pc_seq_arb.sv
// Combinational priority select: halt > stall > jal > branch > increment.
// Zero latency; the enables and offset follow the inputs in the same cycle.
// Optional misalign trap: PC_SEQ_MISALIGN_TRAP_EN (without it, low offset bits are cleared).
import pc_seq_pkg::*;

module pc_seq_arb (
   input  logic                active,
   input  logic                honor_halt,
   input  logic                halt_req,
   input  logic                stall,
   input  logic                jal_en,
   input  logic [OFFSET_W-1:0] jal_offset,
   input  logic                br_taken,
   input  logic [OFFSET_W-1:0] br_offset,
   output logic                branch_en,
   output logic                increment_en,
   output logic [OFFSET_W-1:0] branch_offset,
`ifdef PC_SEQ_MISALIGN_TRAP_EN
   output logic                misalign,
`endif
   output logic                halt_take
);

   logic [OFFSET_W-1:0] sel;

   // Pick exactly one action per cycle; offset stays 0 unless a redirect is issued.
   always_comb begin
      branch_en     = 1'b0;
      increment_en  = 1'b0;
      branch_offset = '0;
      halt_take     = 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      misalign      = 1'b0;
`endif
      sel = jal_en ? jal_offset : br_offset;
      if (active) begin
         if (honor_halt && halt_req) begin
            halt_take = 1'b1;
         end else if (stall) begin
            // hold PC
         end else if (jal_en || br_taken) begin
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            // A misaligned target is not taken; the FSM parks in HALT instead.
            if (|(sel & ~align_mask())) begin
               misalign = 1'b1;
            end else begin
               branch_en     = 1'b1;
               branch_offset = sel;
            end
`else
            branch_en     = 1'b1;
            branch_offset = sel & align_mask();
`endif
         end else begin
            increment_en = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Drives ProgramCounter enables/offset: boot delay, run/halt/step FSM, advance counter.
// Enables are combinational (zero added latency); status and counter are registered.
// Optional misalign trap via PC_SEQ_MISALIGN_TRAP_EN (adds sticky misalign_err output).
import pc_seq_pkg::*;

module pc_sequencer #(
   parameter int BOOT_CYCLES = 4,
   parameter int CNT_W       = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic                stall,
   input  logic                br_taken,
   input  logic [OFFSET_W-1:0] br_offset,
   input  logic                jal_en,
   input  logic [OFFSET_W-1:0] jal_offset,
   input  logic                halt_req,
   input  logic                step_req,
   output logic                branch_en,
   output logic                increment_en,
   output logic [OFFSET_W-1:0] branch_offset,
   output logic                running,
   output logic                halted,
`ifdef PC_SEQ_MISALIGN_TRAP_EN
   output logic                misalign_err,
`endif
   output logic [CNT_W-1:0]    adv_cnt
);

   localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

   pc_seq_state_t       state;
   pc_seq_state_t       state_nxt;
   logic [BW-1:0]       boot_cnt;
   logic                arb_branch;
   logic                arb_incr;
   logic [OFFSET_W-1:0] arb_offset;
   logic                halt_take;
   logic                trap;

   pc_seq_arb u_arb (
      .active        ((state == ST_RUN) || (state == ST_STEP)),
      .honor_halt    (state == ST_RUN),
      .halt_req      (halt_req),
      .stall         (stall),
      .jal_en        (jal_en),
      .jal_offset    (jal_offset),
      .br_taken      (br_taken),
      .br_offset     (br_offset),
      .branch_en     (arb_branch),
      .increment_en  (arb_incr),
      .branch_offset (arb_offset),
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      .misalign      (trap),
`endif
      .halt_take     (halt_take)
   );

`ifndef PC_SEQ_MISALIGN_TRAP_EN
   assign trap = 1'b0;
`endif

   // State register plus status flags that mirror the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_BOOT;
         running <= 1'b0;
         halted  <= 1'b0;
      end else begin
         state   <= state_nxt;
         running <= (state_nxt == ST_RUN);
         halted  <= (state_nxt == ST_HALT);
      end
   end

   // Next-state decision.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_BOOT: if (boot_cnt == '0) state_nxt = ST_IDLE;
         ST_IDLE: if (run) state_nxt = ST_RUN;
         ST_RUN:  if (halt_take || trap) state_nxt = ST_HALT;
         ST_HALT: begin
            if (run)           state_nxt = ST_RUN;
            else if (step_req) state_nxt = ST_STEP;
         end
         // A stalled step waits; any non-stalled cycle completes the step.
         ST_STEP: if (!stall) state_nxt = ST_HALT;
         default: state_nxt = ST_BOOT;
      endcase
   end

   // PC controls: reset overrides whatever the arbiter selected.
   always_comb begin
      branch_en     = 1'b0;
      increment_en  = 1'b0;
      branch_offset = '0;
      if (!rst) begin
         branch_en     = arb_branch;
         increment_en  = arb_incr;
         branch_offset = arb_offset;
      end
   end

   // Boot delay countdown, reloaded only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         boot_cnt <= BW'(BOOT_CYCLES - 1);
      end else if ((state == ST_BOOT) && (boot_cnt != '0)) begin
         boot_cnt <= boot_cnt - BW'(1);
      end
   end

   // Count every cycle in which the PC moves; wraps naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         adv_cnt <= '0;
      end else if (branch_en || increment_en) begin
         adv_cnt <= adv_cnt + CNT_W'(1);
      end
   end

`ifdef PC_SEQ_MISALIGN_TRAP_EN
   // Sticky misalign flag; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_err <= 1'b0;
      end else if (trap) begin
         misalign_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
// Inputs change 1 time unit after posedge; checks run 2 units after posedge.
// Covers the default build and, when PC_SEQ_MISALIGN_TRAP_EN is set, the trap.
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        run;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_offset;
   logic        jal_en;
   logic [31:0] jal_offset;
   logic        halt_req;
   logic        step_req;
   logic        branch_en;
   logic        increment_en;
   logic [31:0] branch_offset;
   logic        running;
   logic        halted;
   logic [31:0] adv_cnt;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
   logic        misalign_err;
`endif

   int vectors;
   int miscompares;
   logic [31:0] exp_cnt;

   pc_sequencer #(.BOOT_CYCLES(4), .CNT_W(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .run           (run),
      .stall         (stall),
      .br_taken      (br_taken),
      .br_offset     (br_offset),
      .jal_en        (jal_en),
      .jal_offset    (jal_offset),
      .halt_req      (halt_req),
      .step_req      (step_req),
      .branch_en     (branch_en),
      .increment_en  (increment_en),
      .branch_offset (branch_offset),
      .running       (running),
      .halted        (halted),
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      .misalign_err  (misalign_err),
`endif
      .adv_cnt       (adv_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the three PC controls together.
   task automatic chk_pc(input string tag, input logic b, input logic i, input logic [31:0] off);
      chk({tag, ".branch_en"}, 64'(branch_en), 64'(b));
      chk({tag, ".increment_en"}, 64'(increment_en), 64'(i));
      chk({tag, ".branch_offset"}, 64'(branch_offset), 64'(off));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      exp_cnt     = 0;
      rst = 1'b1; run = 1'b0; stall = 1'b0; br_taken = 1'b0; br_offset = '0;
      jal_en = 1'b0; jal_offset = '0; halt_req = 1'b0; step_req = 1'b0;

      // ---- reset and boot ----
      tick();
      tick();
      #1;
      chk_pc("reset", 1'b0, 1'b0, 32'h0);
      chk("reset.running", 64'(running), 64'd0);
      chk("reset.halted", 64'(halted), 64'd0);
      chk("reset.adv_cnt", 64'(adv_cnt), 64'd0);
      rst = 1'b0;
      run = 1'b1;
      // four BOOT cycles then one IDLE cycle, none advancing
      for (int c = 1; c <= 5; c++) begin
         #1;
         chk($sformatf("boot%0d.incr", c), 64'(increment_en), 64'd0);
         chk($sformatf("boot%0d.running", c), 64'(running), 64'd0);
         tick();
      end
      // cycle 6: RUN
      #1;
      chk("run6.running", 64'(running), 64'd1);
      chk_pc("run6", 1'b0, 1'b1, 32'h0);
      chk("run6.adv_cnt", 64'(adv_cnt), 64'd0);
      tick(); exp_cnt = 1;
      #1; chk("run7.adv_cnt", 64'(adv_cnt), 64'(exp_cnt));
      tick(); exp_cnt = 2;
      run = 1'b0;
      #1; chk("run8.adv_cnt", 64'(adv_cnt), 64'(exp_cnt));

      // ---- redirect priority ----
      br_taken = 1'b1; br_offset = 32'h12341234;
      #1; chk_pc("branch", 1'b1, 1'b0, 32'h12341234);
      tick(); exp_cnt = 3;
      jal_en = 1'b1; jal_offset = 32'h00000100;
      #1; chk_pc("jal_over_br", 1'b1, 1'b0, 32'h00000100);
      chk("jal_over_br.adv_cnt", 64'(adv_cnt), 64'(exp_cnt));
      tick(); exp_cnt = 4;
      stall = 1'b1;
      #1; chk_pc("stall", 1'b0, 1'b0, 32'h0);
      tick();
      #1; chk("stall.adv_cnt", 64'(adv_cnt), 64'(exp_cnt));

      // ---- halt with redirect suppressed ----
      stall = 1'b0; halt_req = 1'b1;
      #1; chk_pc("halt_sup", 1'b0, 1'b0, 32'h0);
      tick();
      halt_req = 1'b0; br_taken = 1'b0; jal_en = 1'b0;
      #1;
      chk("halt.halted", 64'(halted), 64'd1);
      chk("halt.running", 64'(running), 64'd0);
      chk_pc("halt_idle", 1'b0, 1'b0, 32'h0);
      tick();
      #1; chk("halt.adv_cnt", 64'(adv_cnt), 64'(exp_cnt));

      // ---- three single steps ----
      for (int s = 0; s < 3; s++) begin
         step_req = 1'b1;
         tick();
         step_req = 1'b0;
         #1;
         chk($sformatf("step%0d.halted", s), 64'(halted), 64'd0);
         chk_pc($sformatf("step%0d", s), 1'b0, 1'b1, 32'h0);
         tick(); exp_cnt = exp_cnt + 1;
         #1;
         chk($sformatf("step%0d.back", s), 64'(halted), 64'd1);
         chk_pc($sformatf("step%0d.back", s), 1'b0, 1'b0, 32'h0);
      end
      chk("steps.adv_cnt", 64'(adv_cnt), 64'd7);

      // ---- step held by stall ----
      step_req = 1'b1;
      tick();
      step_req = 1'b0; stall = 1'b1;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk_pc($sformatf("stepstall%0d", c), 1'b0, 1'b0, 32'h0);
         tick();
         #1;
         chk($sformatf("stepstall%0d.halted", c), 64'(halted), 64'd0);
         chk($sformatf("stepstall%0d.running", c), 64'(running), 64'd0);
         chk($sformatf("stepstall%0d.adv_cnt", c), 64'(adv_cnt), 64'(exp_cnt));
      end
      stall = 1'b0; halt_req = 1'b1; // halt request has no effect while stepping
      #1; chk_pc("stepgo", 1'b0, 1'b1, 32'h0);
      tick(); exp_cnt = exp_cnt + 1;
      halt_req = 1'b0;
      #1;
      chk("stepgo.halted", 64'(halted), 64'd1);
      chk("stepgo.adv_cnt", 64'(adv_cnt), 64'(exp_cnt));

      // ---- resume, run beats step ----
      run = 1'b1; step_req = 1'b1;
      #1; chk_pc("resume", 1'b0, 1'b0, 32'h0);
      tick();
      run = 1'b0; step_req = 1'b0;
      #1;
      chk("resume.running", 64'(running), 64'd1);
      chk("resume.halted", 64'(halted), 64'd0);
      chk_pc("resume.first", 1'b0, 1'b1, 32'h0);
      tick(); exp_cnt = exp_cnt + 1;

      // ---- misaligned branch target ----
      br_taken = 1'b1; br_offset = 32'h00000006;
      #1;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      chk_pc("misalign", 1'b0, 1'b0, 32'h0);
      tick();
      br_taken = 1'b0;
      #1;
      chk("misalign.err", 64'(misalign_err), 64'd1);
      chk("misalign.halted", 64'(halted), 64'd1);
      chk("misalign.adv_cnt", 64'(adv_cnt), 64'(exp_cnt));
      run = 1'b1;
      tick();
      run = 1'b0;
`else
      chk_pc("misalign_mask", 1'b1, 1'b0, 32'h00000004);
      tick(); exp_cnt = exp_cnt + 1;
      br_taken = 1'b0;
      #1; chk("misalign_mask.adv_cnt", 64'(adv_cnt), 64'(exp_cnt));
`endif

      // ---- reset during a jump ----
      #1; chk("prerst.running", 64'(running), 64'd1);
      jal_en = 1'b1; jal_offset = 32'h00000040; rst = 1'b1;
      #1; chk_pc("rst_jal", 1'b0, 1'b0, 32'h0);
      tick();
      rst = 1'b0; jal_en = 1'b0;
      #1;
      chk("rst_jal.adv_cnt", 64'(adv_cnt), 64'd0);
      chk("rst_jal.running", 64'(running), 64'd0);
      chk("rst_jal.halted", 64'(halted), 64'd0);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      chk("rst_jal.err", 64'(misalign_err), 64'd0);
`endif
      // boot again, land in IDLE with run low: still no advance
      for (int c = 0; c < 5; c++) tick();
      #1;
      chk_pc("reboot_idle", 1'b0, 1'b0, 32'h0);
      chk("reboot_idle.running", 64'(running), 64'd0);
      run = 1'b1;
      tick();
      run = 1'b0;
      #1;
      chk("reboot_run.running", 64'(running), 64'd1);
      chk_pc("reboot_run", 1'b0, 1'b1, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
